// File: rtl/kronos_mem_arbiter_if.sv
// Bundle of the fetch, load/store and external memory ports shared by kronos_mem_arbiter.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface kronos_mem_arbiter_if;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        instr_err;

  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic        data_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rd_data;

  modport slave (
    input  instr_addr, instr_req,
    input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    input  mem_ack, mem_rd_data,
    output instr_ack, instr_data, instr_err,
    output data_ack, data_rd_data, data_err,
    output mem_addr, mem_wr_data, mem_mask, mem_wr_en, mem_req
  );

  modport master (
    output instr_addr, instr_req,
    output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    output mem_ack, mem_rd_data,
    input  instr_ack, instr_data, instr_err,
    input  data_ack, data_rd_data, data_err,
    input  mem_addr, mem_wr_data, mem_mask, mem_wr_en, mem_req
  );
endinterface

// File: rtl/kronos_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a watchdog that aborts a transfer the memory never acknowledges.
module kronos_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rstz,
  kronos_mem_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state
);

  // Handshake: a requester raises req and holds it (with its address/controls) until
  // its ack pulses for one cycle; err qualifies that ack. On the memory side mem_req
  // stays high until the single-cycle mem_ack, or drops to signal a watchdog abort.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  state_t        state_next;
  logic          last_data;
  logic [CW-1:0] wd_cnt;

  logic busy;
  logic expire;
  logic done;
  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  assign dbg_state = state;

  // Ack beats expiry: an expiry only counts when mem_ack is low in that cycle.
  assign busy   = (state != IDLE);
  assign expire = (TIMEOUT != 0) && busy && (wd_cnt == CNT_LAST) && !bus.mem_ack;
  assign done   = busy && (bus.mem_ack || expire);

  // State register
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state     <= IDLE;
      last_data <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        last_data <= 1'b0;
      end else if (grant_d) begin
        last_data <= 1'b1;
      end
    end
  end

  // Next-state: arbitrate in IDLE and in a completion cycle. The finishing
  // requester is excluded because its req still reflects the completed transfer.
  always_comb begin
    req_i      = bus.instr_req && ((state == IDLE) || ((state == DBUSY) && done));
    req_d      = bus.data_req  && ((state == IDLE) || ((state == IBUSY) && done));
    grant_d    = req_d && (!req_i || !last_data);
    grant_i    = req_i && !grant_d;
    state_next = state;
    if (grant_i) begin
      state_next = IBUSY;
    end else if (grant_d) begin
      state_next = DBUSY;
    end else if (done) begin
      state_next = IDLE;
    end
  end

  // Registered memory-side outputs and watchdog counter
  always_ff @(posedge clk) begin
    if (!rstz) begin
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.mem_mask    <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_req     <= 1'b0;
      wd_cnt          <= '0;
    end else if (grant_i) begin
      bus.mem_addr    <= bus.instr_addr;
      bus.mem_wr_data <= '0;
      bus.mem_mask    <= 4'hF;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_req     <= 1'b1;
      wd_cnt          <= '0;
    end else if (grant_d) begin
      bus.mem_addr    <= bus.data_addr;
      bus.mem_wr_data <= bus.data_wr_data;
      bus.mem_mask    <= bus.data_mask;
      bus.mem_wr_en   <= bus.data_wr_en;
      bus.mem_req     <= 1'b1;
      wd_cnt          <= '0;
    end else if (done) begin
      bus.mem_req <= 1'b0;
    end else if (busy && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Output decode: acks are combinational so mem_ack reaches the requester with no added latency.
  // Holding rstz low suppresses any ack of the abandoned transfer.
  always_comb begin
    bus.instr_ack    = 1'b0;
    bus.instr_err    = 1'b0;
    bus.instr_data   = '0;
    bus.data_ack     = 1'b0;
    bus.data_err     = 1'b0;
    bus.data_rd_data = '0;
    if (rstz && done) begin
      if (state == IBUSY) begin
        bus.instr_ack  = 1'b1;
        bus.instr_err  = !bus.mem_ack;
        bus.instr_data = bus.mem_ack ? bus.mem_rd_data : '0;
      end else if (state == DBUSY) begin
        bus.data_ack     = 1'b1;
        bus.data_err     = !bus.mem_ack;
        bus.data_rd_data = bus.mem_ack ? bus.mem_rd_data : '0;
      end
    end
  end

endmodule
